// File: rtl/seg7_scan_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_if
//
// Bundles the signals between the seven-segment scan driver, the ALU display
// decoder that answers a scan index with a digit code, and the board pins.
//
//   rr           driver -> decoder   current digit scan index, 0..7
//   digit_holder decoder -> driver   5-bit code for digit rr
//   AN           driver -> pins      anode enables, active-low, AN[i] = digit i
//   SEG          driver -> pins      cathodes gfedcba, active-low
//   DP           driver -> pins      decimal point, active-low (always off)
//   frame_tick   driver -> system    one-cycle pulse when rr wraps 7 -> 0
//   brightness   system -> driver    dimming level 0..7 (only when the
//                                    SEG_DIMMING_EN macro is defined)
//
// master: the scan driver.  slave: decoder / display side.
// ---------------------------------------------------------------------------
interface seg7_scan_if;
  logic [2:0] rr;
  logic [4:0] digit_holder;
  logic [7:0] AN;
  logic [6:0] SEG;
  logic       DP;
  logic       frame_tick;
`ifdef SEG_DIMMING_EN
  logic [2:0] brightness;

  modport master (
    output rr, AN, SEG, DP, frame_tick,
    input  digit_holder, brightness
  );

  modport slave (
    input  rr, AN, SEG, DP, frame_tick,
    output digit_holder, brightness
  );
`else
  modport master (
    output rr, AN, SEG, DP, frame_tick,
    input  digit_holder
  );

  modport slave (
    input  rr, AN, SEG, DP, frame_tick,
    output digit_holder
  );
`endif
endinterface : seg7_scan_if

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexed driver for the Nexys A7 8-digit seven-segment display.
// Each digit owns a slot of REFRESH_DIV clock cycles. The first GUARD_CYCLES
// cycles of every slot keep all anodes off so the cathodes can settle on the
// new digit before it lights, which removes ghosting of the previous digit.
//
// Ports:
//   CLK100MHZ   system clock (100 MHz)
//   CPU_RESETN  asynchronous active-low reset
//   disp        seg7_scan_if.master: rr out, digit_holder in, AN/SEG/DP
//               and frame_tick out (plus brightness in when dimming is on)
//
// Parameters:
//   REFRESH_DIV   cycles per digit slot, must exceed GUARD_CYCLES+1
//   GUARD_CYCLES  blanked cycles at the start of each slot, must be >= 2
//
// Optional feature (macro SEG_DIMMING_EN): adds a brightness input and a
// free-running 3-bit PWM counter; during the lit window the anode is only
// enabled while pwm <= brightness (7 = full duty, 0 = 1/8 duty).
//
// AN, SEG and frame_tick are all driven straight from flops; digit_holder
// only reaches SEG through a register, so no combinational path exists from
// the decoder to the pins.
// ---------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 64
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  seg7_scan_if.master  disp
);

  // -------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // -------------------------------------------------------------------------
  if (GUARD_CYCLES < 2) begin : g_bad_guard
    $error("seg7_scan_driver: GUARD_CYCLES must be >= 2");
  end
  if (REFRESH_DIV <= GUARD_CYCLES + 1) begin : g_bad_div
    $error("seg7_scan_driver: REFRESH_DIV must be > GUARD_CYCLES+1");
  end

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,  // all anodes off while SEG settles on the new digit
    ST_ON    = 1'b1   // anode for rr enabled until the end of the slot
  } state_t;

  // -------------------------------------------------------------------------
  // Digit code -> active-low gfedcba pattern
  // -------------------------------------------------------------------------
  function automatic logic [6:0] seg_encode(input logic [4:0] code);
    logic [6:0] pat;
    pat = 7'h7F;
    case (code)
      5'd0:  pat = 7'h40;
      5'd1:  pat = 7'h79;
      5'd2:  pat = 7'h24;
      5'd3:  pat = 7'h30;
      5'd4:  pat = 7'h19;
      5'd5:  pat = 7'h12;
      5'd6:  pat = 7'h02;
      5'd7:  pat = 7'h78;
      5'd8:  pat = 7'h00;
      5'd9:  pat = 7'h10;
      5'd10: pat = 7'h08;
      5'd11: pat = 7'h03;
      5'd12: pat = 7'h46;
      5'd13: pat = 7'h21;
      5'd14: pat = 7'h06;
      5'd15: pat = 7'h0E;
      5'd17: pat = 7'h3F;  // minus: segment g only
      default: pat = 7'h7F; // 16 and 18..31 are blank
    endcase
    return pat;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rr_q;
  state_t           state;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             frame_q;

  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       rr_nxt;
  state_t           state_nxt;
  logic [7:0]       an_nxt;
  logic             frame_nxt;

`ifdef SEG_DIMMING_EN
  logic [2:0] pwm;
  logic [2:0] pwm_nxt;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic. The anode register is loaded from the *next* state so
  // that AN changes in the same cycle as rr and the FSM state, with no
  // decode logic between the flops and the pins.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    cnt_nxt   = cnt + 1'b1;
    rr_nxt    = rr_q;
    state_nxt = state;
    frame_nxt = 1'b0;
    an_nxt    = 8'hFF;

    if (cnt == CNT_LAST) begin
      cnt_nxt   = '0;
      rr_nxt    = rr_q + 3'd1;
      state_nxt = ST_GUARD;
      // High in the first cycle rr reads 0 after a 7 -> 0 wrap.
      frame_nxt = (rr_q == 3'd7);
    end else if (state == ST_GUARD && cnt == GUARD_LAST) begin
      state_nxt = ST_ON;
    end

    if (state_nxt == ST_ON) begin
      an_nxt = ~(8'b1 << rr_nxt);
    end

`ifdef SEG_DIMMING_EN
    pwm_nxt = pwm + 3'd1;
    // Compare against the value pwm will hold when this AN is visible, so a
    // brightness change shows up on the pins in the following cycle.
    if (pwm_nxt > disp.brightness) begin
      an_nxt = 8'hFF;
    end
`endif
  end

  // -------------------------------------------------------------------------
  // Registers: slot counter, scan index, FSM state and all pin drivers.
  // Reset is asynchronous and overrides every update, including a slot wrap.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    if (!CPU_RESETN) begin
      cnt     <= '0;
      rr_q    <= 3'd0;
      state   <= ST_GUARD;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      frame_q <= 1'b0;
`ifdef SEG_DIMMING_EN
      pwm     <= 3'd0;
`endif
    end else begin
      cnt     <= cnt_nxt;
      rr_q    <= rr_nxt;
      state   <= state_nxt;
      an_q    <= an_nxt;
      // The decoder output is sampled every cycle, so SEG trails rr by one
      // cycle; the guard window hides that lag behind dark anodes.
      seg_q   <= seg_encode(disp.digit_holder);
      frame_q <= frame_nxt;
`ifdef SEG_DIMMING_EN
      pwm     <= pwm_nxt;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign disp.rr         = rr_q;
  assign disp.AN         = an_q;
  assign disp.SEG        = seg_q;
  assign disp.DP         = 1'b1;
  assign disp.frame_tick = frame_q;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver with REFRESH_DIV=16 and
// GUARD_CYCLES=4. The bench plays the role of the display decoder through a
// per-digit code table and keeps a timeline model: everything expected is
// derived from the number of clock edges since reset release.
// Build with +define+SEG_DIMMING_EN to exercise the dimming feature.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int DIV   = 16;
  localparam int GUARD = 4;
  localparam int FRAME = DIV * 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  seg7_scan_if bus ();

  // Decoder stand-in: the code returned for each scan index.
  logic [4:0] dec_map [8];
  assign bus.digit_holder = dec_map[bus.rr];

`ifdef SEG_DIMMING_EN
  logic [2:0] brightness = 3'd7;
  assign bus.brightness = brightness;
`endif

  seg7_scan_driver #(
    .REFRESH_DIV (DIV),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rst_n),
    .disp      (bus)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference encoding table (active-low gfedcba), straight from the digit
  // glyph list: 0..F, then 17 is a minus and every other code is blank.
  // -------------------------------------------------------------------------
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] exp_seg(input logic [4:0] code);
    if (code < 5'd16) return HEX_SEG[code[3:0]];
    if (code == 5'd17) return 7'h3F;
    return 7'h7F;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  // -------------------------------------------------------------------------
  // Timeline model. m_t counts rising edges since reset release; the visible
  // slot, scan index and position follow by division. m_seg holds the glyph
  // of the code that was presented at the latest edge.
  // -------------------------------------------------------------------------
  int         m_t   = 0;
  logic [6:0] m_seg = 7'h7F;
`ifdef SEG_DIMMING_EN
  logic [2:0] m_bright = 3'd7;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t   = 0;
      m_seg = 7'h7F;
    end else begin
      m_seg = exp_seg(dec_map[(m_t / DIV) % 8]);
`ifdef SEG_DIMMING_EN
      m_bright = brightness;
`endif
      m_t = m_t + 1;
    end
  end

  function automatic int m_rr();
    return (m_t / DIV) % 8;
  endfunction

  function automatic int m_pos();
    return m_t % DIV;
  endfunction

  function automatic logic [7:0] m_an();
    logic [7:0] a;
    a = (m_pos() < GUARD) ? 8'hFF : ~(8'(1) << m_rr());
`ifdef SEG_DIMMING_EN
    // pwm restarts at 0 with reset and steps every cycle.
    if ((m_t % 8) > int'(m_bright)) a = 8'hFF;
`endif
    return a;
  endfunction

  // -------------------------------------------------------------------------
  // Per-cycle compare against the model, on the falling edge.
  // -------------------------------------------------------------------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rr",         32'(bus.rr),         32'(m_rr()));
      check("AN",         32'(bus.AN),         32'(m_an()));
      check("SEG",        32'(bus.SEG),        32'(m_seg));
      check("DP",         32'(bus.DP),         32'd1);
      check("frame_tick", 32'(bus.frame_tick),
            32'((m_t != 0) && (m_t % FRAME == 0)));
    end
  end

  // Advance to the falling edge at which the model reads time `target`.
  task automatic goto_t(input int target);
    int guard_cnt;
    guard_cnt = 0;
    do begin
      @(negedge clk);
      guard_cnt++;
    end while (m_t != target && guard_cnt < 5000);
    check("goto_t_reached", 32'(m_t), 32'(target));
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int hits;
    int budget;

    dec_map[0] = 5'd16;
    for (int i = 1; i < 8; i++) dec_map[i] = 5'(i + 3);

    // ---- reset held 5 cycles, then release on a falling edge ------------
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_AN",  32'(bus.AN),  32'hFF);
    check("rst_SEG", 32'(bus.SEG), 32'h7F);
    check("rst_rr",  32'(bus.rr),  32'd0);
    rst_n = 1'b1;

    repeat (3) @(negedge clk);
    check("c3_AN",  32'(bus.AN),  32'hFF);
    check("c3_SEG", 32'(bus.SEG), 32'h7F);
    check("c3_rr",  32'(bus.rr),  32'd0);
    @(negedge clk);
    check("c4_AN",  32'(bus.AN),  32'hFE);
    repeat (11) @(negedge clk);
    check("c15_AN", 32'(bus.AN),  32'hFE);
    @(negedge clk);
    check("c16_rr", 32'(bus.rr),  32'd1);
    check("c16_AN", 32'(bus.AN),  32'hFF);

    // ---- scan with decoder returning rr+3 -------------------------------
    goto_t(24);
    check("rr1_SEG", 32'(bus.SEG), 32'h19);
    check("rr1_AN",  32'(bus.AN),  32'hFD);
    goto_t(7 * DIV + 8);
    check("rr7_SEG", 32'(bus.SEG), 32'h08);
    check("rr7_AN",  32'(bus.AN),  32'h7F);

    // ---- special codes in successive slots of the next frame -------------
    dec_map[2] = 5'd16;
    dec_map[3] = 5'd17;
    dec_map[4] = 5'd31;
    dec_map[5] = 5'd10;
    goto_t(FRAME - 1);
    check("tick_before", 32'(bus.frame_tick), 32'd0);
    @(negedge clk);
    check("tick_wrap",   32'(bus.frame_tick), 32'd1);
    check("tick_rr",     32'(bus.rr),         32'd0);
    @(negedge clk);
    check("tick_after",  32'(bus.frame_tick), 32'd0);

    // Digit change 1 -> 2: old glyph for one cycle, anodes dark meanwhile.
    goto_t(FRAME + 2 * DIV);
    check("ghost_old_SEG", 32'(bus.SEG), 32'h19);
    check("ghost_old_AN",  32'(bus.AN),  32'hFF);
    @(negedge clk);
    check("ghost_new_SEG", 32'(bus.SEG), 32'h7F);
    check("ghost_new_AN",  32'(bus.AN),  32'hFF);
    goto_t(FRAME + 2 * DIV + 8);
    check("code16_SEG", 32'(bus.SEG), 32'h7F);
    check("code16_AN",  32'(bus.AN),  32'hFB);
    goto_t(FRAME + 3 * DIV + 8);
    check("code17_SEG", 32'(bus.SEG), 32'h3F);
    goto_t(FRAME + 4 * DIV + 8);
    check("code31_SEG", 32'(bus.SEG), 32'h7F);
    goto_t(FRAME + 5 * DIV + 8);
    check("code10_SEG", 32'(bus.SEG), 32'h08);
    check("code10_AN",  32'(bus.AN),  32'hDF);
    check("code10_DP",  32'(bus.DP),  32'd1);

`ifdef SEG_DIMMING_EN
    // ---- dimming duty over one 8-cycle PWM period in the lit window -----
    brightness = 3'd1;
    goto_t(FRAME + 6 * DIV + GUARD - 1);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.AN != 8'hFF) hits++;
    end
    check("duty_b1", 32'(hits), 32'd2);
    brightness = 3'd0;
    goto_t(FRAME + 7 * DIV + GUARD - 1);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.AN != 8'hFF) hits++;
    end
    check("duty_b0", 32'(hits), 32'd1);
    brightness = 3'd7;
    goto_t(2 * FRAME + GUARD - 1);
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.AN != 8'hFF) hits++;
    end
    check("duty_b7", 32'(hits), 32'd8);
`endif

    // ---- randomized decoder codes (and brightness) -----------------------
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) dec_map[$urandom_range(0, 7)] = 5'($urandom);
`ifdef SEG_DIMMING_EN
      if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
`endif
    end

    // ---- asynchronous reset in the middle of slot rr=5 -------------------
`ifdef SEG_DIMMING_EN
    brightness = 3'd7;
`endif
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(m_rr() == 5 && m_pos() == 9) && budget < 400);
    check("mid_reached", 32'(m_rr() * 100 + m_pos()), 32'd509);
    check("mid_pre_AN",  32'(bus.AN), 32'hDF);
    #2 rst_n = 1'b0;
    #1;
    check("mid_async_AN",    32'(bus.AN),         32'hFF);
    check("mid_async_SEG",   32'(bus.SEG),        32'h7F);
    check("mid_async_rr",    32'(bus.rr),         32'd0);
    check("mid_async_frame", 32'(bus.frame_tick), 32'd0);
    repeat (3) @(negedge clk);
    dec_map[0] = 5'd8;
    rst_n = 1'b1;
    repeat (GUARD) @(negedge clk);
    check("restart_AN",  32'(bus.AN),  32'hFE);
    check("restart_rr",  32'(bus.rr),  32'd0);
    check("restart_SEG", 32'(bus.SEG), 32'h00);
    repeat (300) @(negedge clk);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_seg7_scan_driver
